// File: rtl/rr_arbiter4.sv
// rr_arbiter4: round-robin arbiter sharing one resource among four requesters.
//
// Grants are registered and one-hot. The owner keeps the grant while its request
// stays high, up to HOLD_MAX consecutive cycles, after which it is force-released
// with a one-cycle timeout pulse. Every release is followed by at least one idle
// cycle. Contention statistics are sampled on each grant decision.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   req[3:0]     request per requester (bit k = requester k)
//   gnt[3:0]     one-hot grant or all zero
//   owner[1:0]   index of current grant holder, valid when busy=1
//   busy         high while any gnt bit is high
//   timeout      one-cycle pulse following a forced release
//   contend_cnt  saturating count of decisions taken with 2 or 3 requests active
//   all4_seen    sticky: a decision was taken with all 4 requests active
module rr_arbiter4 #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    output logic [3:0]    gnt,
    output logic [1:0]    owner,
    output logic          busy,
    output logic          timeout,
    output logic [CW-1:0] contend_cnt,
    output logic          all4_seen
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [7:0]    hold_q, hold_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    owner_q, owner_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          all4_q, all4_d;

    logic [1:0]    pick;
    logic [1:0]    idx;
    logic          found;
    logic [2:0]    req_pop;
    logic          hold_done;

    // First set request bit scanning ptr, ptr+1, ... (mod 4).
    always_comb begin
        pick  = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign req_pop   = 3'(req[0]) + 3'(req[1]) + 3'(req[2]) + 3'(req[3]);
    assign hold_done = (hold_q == 8'(HOLD_MAX));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        all4_d    = all4_q;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    gnt_d   = 4'b0001 << pick;
                    owner_d = pick;
                    busy_d  = 1'b1;
                    hold_d  = 8'd1;
                    state_d = StGrant;
                    if ((req_pop == 3'd2) || (req_pop == 3'd3)) begin
                        if (cnt_q != {CW{1'b1}}) begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    if (req_pop == 3'd4) begin
                        all4_d = 1'b1;
                    end
                end
            end
            StGrant: begin
                // Release always returns to idle, giving the mandatory gap cycle.
                if (!req[owner_q] || hold_done) begin
                    gnt_d     = 4'b0000;
                    busy_d    = 1'b0;
                    hold_d    = 8'd0;
                    ptr_d     = owner_q + 2'd1;
                    state_d   = StIdle;
                    timeout_d = req[owner_q];
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= 2'd0;
            hold_q    <= 8'd0;
            gnt_q     <= 4'b0000;
            owner_q   <= 2'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            all4_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            all4_q    <= all4_d;
        end
    end

    assign gnt         = gnt_q;
    assign owner       = owner_q;
    assign busy        = busy_q;
    assign timeout     = timeout_q;
    assign contend_cnt = cnt_q;
    assign all4_seen   = all4_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Testbench for rr_arbiter4: directed steps plus random requests, compared each
// cycle against a behavioural model. A second instance with CW=2 shares all
// stimulus to exercise counter saturation.
module tb_rr_arbiter4;

    localparam int HOLD_MAX = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;

    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;
    logic [7:0] contend_cnt;
    logic       all4_seen;

    logic [3:0] gnt2;
    logic [1:0] owner2;
    logic       busy2;
    logic       timeout2;
    logic [1:0] contend_cnt2;
    logic       all4_seen2;

    rr_arbiter4 #(.HOLD_MAX(HOLD_MAX), .CW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .owner       (owner),
        .busy        (busy),
        .timeout     (timeout),
        .contend_cnt (contend_cnt),
        .all4_seen   (all4_seen)
    );

    rr_arbiter4 #(.HOLD_MAX(HOLD_MAX), .CW(2)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt2),
        .owner       (owner2),
        .busy        (busy2),
        .timeout     (timeout2),
        .contend_cnt (contend_cnt2),
        .all4_seen   (all4_seen2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: m_own = -1 means nobody holds the resource.
    int m_own;
    int m_ptr;
    int m_held;
    int m_cnt;
    bit m_all4;
    bit m_to;
    int grant_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own  = -1;
        m_ptr  = 0;
        m_held = 0;
        m_cnt  = 0;
        m_all4 = 0;
        m_to   = 0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        int pc;
        m_to = 0;
        if (m_own < 0) begin
            if (r != 4'b0000) begin
                pc = $countones(r);
                if (pc == 2 || pc == 3) m_cnt++;
                if (pc == 4) m_all4 = 1;
                for (int i = 0; i < 4; i++) begin
                    if (m_own < 0 && r[(m_ptr + i) % 4]) m_own = (m_ptr + i) % 4;
                end
                m_held = 1;
                grant_log.push_back(m_own);
            end
        end else if (!r[m_own]) begin
            m_ptr = (m_own + 1) % 4;
            m_own = -1;
        end else if (m_held == HOLD_MAX) begin
            m_ptr = (m_own + 1) % 4;
            m_own = -1;
            m_to  = 1;
        end else begin
            m_held++;
        end
    endtask

    task automatic check_all();
        logic [3:0] eg;
        eg = (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("busy", 32'(busy), 32'(m_own >= 0));
        if (m_own >= 0) chk("owner", 32'(owner), 32'(m_own));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("contend_cnt", 32'(contend_cnt), 32'((m_cnt > 255) ? 255 : m_cnt));
        chk("all4_seen", 32'(all4_seen), 32'(m_all4));
        chk("gnt_sat", 32'(gnt2), 32'(eg));
        chk("contend_sat", 32'(contend_cnt2), 32'((m_cnt > 3) ? 3 : m_cnt));
        chk("onehot", 32'($countones(gnt) <= 1), 32'(1));
        chk("to_vs_gnt", 32'(timeout && (gnt != 4'b0000)), 32'(0));
    endtask

    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        rst = 1'b0;
        req = 4'b0000;
        model_reset();
        #2;
        do_reset();

        // Single request, then release.
        step(4'b0100);
        chk("first_gnt", 32'(gnt), 32'h4);
        chk("first_owner", 32'(owner), 32'd2);
        step(4'b0000);
        chk("first_release", 32'(gnt), 32'h0);

        // All four requesting: rotation 0,1,2,3,0 with timeouts.
        do_reset();
        grant_log.delete();
        for (int i = 0; i < 40; i++) step(4'b1111);
        chk("rr_count", 32'(grant_log.size()), 32'd5);
        for (int i = 0; i < grant_log.size() && i < 5; i++) begin
            chk("rr_order", 32'(grant_log[i]), 32'(i % 4));
        end
        chk("rr_all4", 32'(all4_seen), 32'd1);
        chk("rr_cnt", 32'(contend_cnt), 32'd0);
        step(4'b0000);

        // Two requesters: owner 0 releases while 1 waits.
        do_reset();
        step(4'b0011);
        chk("two_gnt0", 32'(gnt), 32'h1);
        chk("two_cnt", 32'(contend_cnt), 32'd1);
        step(4'b0010);
        chk("two_gap", 32'(gnt), 32'h0);
        step(4'b0010);
        chk("two_gnt1", 32'(gnt), 32'h2);
        chk("two_cnt2", 32'(contend_cnt), 32'd1);
        step(4'b0000);

        // Lone requester held: timeout then re-grant to the same line.
        do_reset();
        for (int i = 0; i < 20; i++) step(4'b1000);
        step(4'b0000);

        // Saturation on the CW=2 instance.
        do_reset();
        for (int i = 0; i < 50; i++) step(4'b0111);
        chk("sat_cnt", 32'(contend_cnt2), 32'd3);
        step(4'b0000);

        // Reset during a grant on owner 1 drops gnt before the next edge.
        do_reset();
        step(4'b0010);
        step(4'b0010);
        chk("pre_rst_gnt", 32'(gnt), 32'h2);
        rst = 1'b1;
        #1;
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_busy", 32'(busy), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(4'b1110);
        chk("post_rst_gnt", 32'(gnt), 32'h2);
        step(4'b0000);

        // Random traffic, requests tend to persist to exercise holds and timeouts.
        do_reset();
        begin
            logic [3:0] r;
            r = 4'b0000;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
                step(r);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Round-robin arbiter that shares one resource among four requesters.
- Grants are one-hot and registered. A grant is held while the owner keeps its request high, and is cut off at a hold limit.
- Tracks contention statistics using two-or-three-active classification of the request vector.
- Sits between the four requesting lab circuits and the shared resource; the statistics feed the lab's debug readout.

Parameters:
- HOLD_MAX, 8, maximum consecutive cycles a grant may be held (legal 2..255).
- CW, 8, width of the contention counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  4  request per requester; bit k belongs to requester k
- gnt  output  4  one-hot grant, or all zero
- owner  output  2  index of current grant holder; valid only when busy=1
- busy  output  1  high while any gnt bit is high
- timeout  output  1  one-cycle pulse on a forced release
- contend_cnt  output  CW  saturating count of arbitration decisions taken with exactly 2 or 3 requests active
- all4_seen  output  1  sticky flag: an arbitration decision was taken with all 4 requests active

Behaviour:
- Reset (async, immediate):
  - gnt=0, owner=0, busy=0, timeout=0, contend_cnt=0, all4_seen=0.
  - Priority pointer ptr=0; state=IDLE; hold counter=0.
  - Reset asserted mid-grant drops gnt in the same cycle, without waiting for an edge.
- States: IDLE and GRANT.
- IDLE:
  - gnt=0.
  - At an edge with req!=0, pick the first set bit scanning ptr, ptr+1, ... mod 4.
  - At that edge: gnt[pick]=1, owner=pick, busy=1, hold counter=1, state=GRANT.
  - Latency: req sampled at edge N, gnt visible after edge N (one cycle from request to grant).
- GRANT, normal release:
  - At an edge with req[owner]=0: gnt=0, busy=0, ptr=owner+1 mod 4, state=IDLE.
  - Requests on other lines are ignored while in GRANT.
- GRANT, forced release:
  - At an edge with req[owner]=1 and hold counter=HOLD_MAX: gnt=0, busy=0, ptr=owner+1 mod 4, timeout=1 for exactly the following cycle, state=IDLE.
  - Otherwise the hold counter increments.
  - Net effect: gnt is high for exactly HOLD_MAX cycles.
- Mandatory gap:
  - Every release is followed by at least one cycle with gnt=0, including back-to-back requests.
  - No owner-to-owner handover on the same edge.
- Fairness:
  - After a release by k, requester k has lowest priority in the next decision.
  - With all four requesting continuously, grants cycle 0,1,2,3,0...
- A requester that was just force-released and still holds req may be re-granted only when no other line requests.
- Statistics, evaluated only at IDLE edges where a grant is issued:
  - popcount(req) in {2,3}: contend_cnt increments, saturating at all-ones with no wrap.
  - popcount(req)=4: all4_seen set; contend_cnt unchanged.
  - Classification uses the same req sample as the arbitration decision.
- Invariants: gnt is 0 or one-hot at all times; busy equals |gnt; timeout never coincides with gnt=1.

Test Plan:
- Reset then req=4'b0100 → gnt=4'b0100 one cycle later, owner=2, busy=1.
  - Drop req[2] → gnt=0 next cycle; contend_cnt=0.
- req=4'b1111 held for 40 cycles, HOLD_MAX=8 → grants 0,1,2,3,0 in order.
  - Each grant lasts 8 cycles, with a 1-cycle gap and a timeout pulse after each.
  - all4_seen=1; contend_cnt=0.
- req=4'b0011, owner 0 releases while req[1] is held → gap cycle, then gnt=4'b0010.
  - contend_cnt=1 after the first decision.
  - The second decision sees popcount 1, so contend_cnt stays 1.
- Single requester req=4'b1000 held for 20 cycles → gnt[3] high 8 cycles, timeout, gap, re-grant to 3.
- CW=2 with 5 decisions on req=4'b0111 → contend_cnt saturates at 3.
- Assert rst during a grant on owner 1 → gnt=0 and busy=0 immediately, before the next edge.
  - After rst drops with req=4'b1110 → gnt=4'b0010, since ptr was reset to 0.
